// File: rtl/bbcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
package bbcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ADJ   = 2'd1,
    S_SHIFT = 2'd2,
    S_FIN   = 2'd3
  } bbcd_state_e;

  // Decimal digits of 2^width - 1: floor(width*log10(2)) + 1.
  function automatic int bbcd_min_digits(input int width);
    return (width * 32'sd30103) / 32'sd100000 + 32'sd1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit correction step: add 3 when the digit is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  // Combinational add-3 correction
  always_comb begin
    if (digit >= 4'd5) begin
      adjusted = digit + 4'd3;
    end else begin
      adjusted = digit;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with signed mode,
// sticky overflow, BUSY and a one-cycle DONE pulse.
module bin2bcd_seq
  import bbcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  INIT,
  input  logic                  SGN_MODE,
  input  logic [WIDTH-1:0]      BIN,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  NEG,
  output logic                  OVF,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0]    CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAG_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  bbcd_state_e      state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] mag_r;
  logic [BW-1:0]    work_r;
  logic             sign_r;
  logic             ovf_r;
  logic [BW-1:0]    bcd_r;
  logic             neg_r;
  logic             ovf_out_r;
  logic             busy_r;
  logic             done_r;

  logic [BW-1:0]    adj_s;
  logic [BW-1:0]    work_shift_s;
  logic [WIDTH-1:0] mag_shift_s;
  logic [WIDTH-1:0] mag_load_s;
  logic             ovf_shift_s;
  logic             sign_load_s;
  logic [CW-1:0]    cnt_dec_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (work_r[4*g +: 4]),
      .adjusted (adj_s[4*g +: 4])
    );
  end

  // Operand magnitude and next shift step; -2^(WIDTH-1) negates to itself,
  // which read unsigned is exactly its magnitude.
  always_comb begin
    sign_load_s = SGN_MODE & BIN[WIDTH-1];
    if (sign_load_s) begin
      mag_load_s = ~BIN + MAG_ONE;
    end else begin
      mag_load_s = BIN;
    end
    work_shift_s = {work_r[BW-2:0], mag_r[WIDTH-1]};
    mag_shift_s  = {mag_r[WIDTH-2:0], 1'b0};
    ovf_shift_s  = ovf_r | work_r[BW-1];
    cnt_dec_s    = cnt_r - CNT_ONE;
  end

  // Control FSM and datapath; results load from the final shift values
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      mag_r     <= '0;
      work_r    <= '0;
      sign_r    <= 1'b0;
      ovf_r     <= 1'b0;
      bcd_r     <= '0;
      neg_r     <= 1'b0;
      ovf_out_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          done_r <= 1'b0;
          if (INIT) begin
            mag_r   <= mag_load_s;
            sign_r  <= sign_load_s;
            work_r  <= '0;
            ovf_r   <= 1'b0;
            cnt_r   <= CNT_LOAD;
            busy_r  <= 1'b1;
            state_r <= S_ADJ;
          end else begin
            busy_r  <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        S_ADJ: begin
          work_r  <= adj_s;
          state_r <= S_SHIFT;
        end
        S_SHIFT: begin
          work_r <= work_shift_s;
          mag_r  <= mag_shift_s;
          ovf_r  <= ovf_shift_s;
          cnt_r  <= cnt_dec_s;
          if (cnt_dec_s == '0) begin
            bcd_r     <= work_shift_s;
            neg_r     <= sign_r;
            ovf_out_r <= ovf_shift_s;
            done_r    <= 1'b1;
            state_r   <= S_FIN;
          end else begin
            state_r <= S_ADJ;
          end
        end
        S_FIN: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign BCD  = bcd_r;
  assign NEG  = neg_r;
  assign OVF  = ovf_out_r;
  assign BUSY = busy_r;
  assign DONE = done_r;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: 5-digit and 3-digit instances, 16-bit operand.
module tb_bin2bcd_seq;
  import bbcd_pkg::*;

  localparam int W = 16;

  logic        CLK   = 1'b0;
  logic        RST   = 1'b1;
  logic        init5 = 1'b0;
  logic        init3 = 1'b0;
  logic        sgn   = 1'b0;
  logic [15:0] bin   = 16'd0;

  logic [19:0] bcd5;
  logic        neg5, ovf5, busy5, done5;
  logic [11:0] bcd3;
  logic        neg3, ovf3, busy3, done3;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut5 (
    .CLK(CLK), .RST(RST), .INIT(init5), .SGN_MODE(sgn), .BIN(bin),
    .BCD(bcd5), .NEG(neg5), .OVF(ovf5), .BUSY(busy5), .DONE(done5)
  );

  bin2bcd_seq #(.WIDTH(16), .DIGITS(3)) dut3 (
    .CLK(CLK), .RST(RST), .INIT(init3), .SGN_MODE(sgn), .BIN(bin),
    .BCD(bcd3), .NEG(neg3), .OVF(ovf3), .BUSY(busy3), .DONE(done3)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [19:0] bcd;
    logic        neg;
    logic        ovf;
    int          at;
  } exp_t;

  exp_t q5[$];
  exp_t q3[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: magnitude by plain arithmetic, decimal digits by div/mod
  function automatic exp_t model(input logic [15:0] b, input logic s, input int digits, input int at);
    exp_t e;
    int   mag, p10, r;
    mag = (s && b[15]) ? (65536 - int'(b)) : int'(b);
    p10 = 1;
    for (int i = 0; i < digits; i++) p10 = p10 * 10;
    e.neg = s && b[15];
    e.ovf = (mag >= p10);
    r     = mag % p10;
    e.bcd = '0;
    for (int i = 0; i < digits; i++) begin
      e.bcd[4*i +: 4] = 4'(r % 10);
      r = r / 10;
    end
    e.at = at;
    return e;
  endfunction

  always @(negedge CLK) begin
    exp_t e;
    if (done5) begin
      if (q5.size() == 0) begin
        chk("d5_extra_done", {31'd0, done5}, 32'd0);
      end else begin
        e = q5.pop_front();
        chk("d5_done_cycle", cyc, e.at);
        chk("d5_bcd", {12'd0, bcd5}, {12'd0, e.bcd});
        chk("d5_neg", {31'd0, neg5}, {31'd0, e.neg});
        chk("d5_ovf", {31'd0, ovf5}, {31'd0, e.ovf});
      end
    end else if (q5.size() > 0 && cyc > q5[0].at) begin
      chk("d5_done_missing", {31'd0, done5}, 32'd1);
      void'(q5.pop_front());
    end
  end

  always @(negedge CLK) begin
    exp_t e;
    if (done3) begin
      if (q3.size() == 0) begin
        chk("d3_extra_done", {31'd0, done3}, 32'd0);
      end else begin
        e = q3.pop_front();
        chk("d3_done_cycle", cyc, e.at);
        chk("d3_bcd", {20'd0, bcd3}, {12'd0, e.bcd});
        chk("d3_neg", {31'd0, neg3}, {31'd0, e.neg});
        chk("d3_ovf", {31'd0, ovf3}, {31'd0, e.ovf});
      end
    end else if (q3.size() > 0 && cyc > q3[0].at) begin
      chk("d3_done_missing", {31'd0, done3}, 32'd1);
      void'(q3.pop_front());
    end
  end

  // Called at a negedge with the selected DUT idle; returns at the negedge it is idle again.
  task automatic conv(input logic [15:0] b, input logic s, input bit use3, input bit glitch);
    int   acc;
    exp_t e;
    bin = b;
    sgn = s;
    if (use3) init3 = 1'b1; else init5 = 1'b1;
    acc = cyc + 1;
    e = model(b, s, use3 ? 3 : 5, acc + 2*W);
    if (use3) q3.push_back(e); else q5.push_back(e);
    @(negedge CLK);
    init3 = 1'b0;
    init5 = 1'b0;
    chk("busy_after_accept", {31'd0, use3 ? busy3 : busy5}, 32'd1);
    if (glitch) begin
      @(negedge CLK);
      bin = 16'($urandom);
      sgn = ~s;
      if (use3) init3 = 1'b1; else init5 = 1'b1;
      @(negedge CLK);
      init3 = 1'b0;
      init5 = 1'b0;
    end
    while (cyc < acc + 2*W) @(negedge CLK);
    if (glitch) begin
      if (use3) init3 = 1'b1; else init5 = 1'b1;
    end
    @(negedge CLK);
    init3 = 1'b0;
    init5 = 1'b0;
    chk("busy_after_fin", {31'd0, use3 ? busy3 : busy5}, 32'd0);
    chk("done_after_fin", {31'd0, use3 ? done3 : done5}, 32'd0);
  endtask

  initial begin
    int a1;
    repeat (3) @(negedge CLK);
    chk("rst_bcd5", {12'd0, bcd5}, 32'd0);
    chk("rst_flags5", {28'd0, neg5, ovf5, busy5, done5}, 32'd0);
    chk("rst_bcd3", {20'd0, bcd3}, 32'd0);
    chk("min_digits16", bbcd_min_digits(16), 32'd5);
    RST = 1'b0;
    @(negedge CLK);

    conv(16'hFFFF, 1'b0, 1'b0, 1'b0);
    conv(16'h8000, 1'b1, 1'b0, 1'b0);
    conv(16'hFFFF, 1'b1, 1'b0, 1'b0);
    conv(16'h0000, 1'b1, 1'b0, 1'b0);
    conv(16'h7FFF, 1'b1, 1'b0, 1'b0);
    conv(16'd1234, 1'b0, 1'b1, 1'b0);
    conv(16'd999,  1'b0, 1'b1, 1'b0);
    conv(16'h8000, 1'b1, 1'b1, 1'b0);
    conv(16'd5555, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) conv(16'($urandom), 1'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)  conv(16'($urandom), 1'($urandom), 1'b1, 1'b0);

    // INIT held high: back-to-back conversions every 2*W+2 cycles
    bin   = 16'd42;
    sgn   = 1'b0;
    init5 = 1'b1;
    a1    = cyc + 1;
    for (int k = 0; k < 3; k++) q5.push_back(model(16'd42, 1'b0, 5, a1 + k*(2*W+2) + 2*W));
    repeat (2*(2*W+2) + 1) @(negedge CLK);
    init5 = 1'b0;
    while (cyc < a1 + 2*(2*W+2) + 2*W + 1) @(negedge CLK);

    // Asynchronous reset in the middle of a conversion
    bin   = 16'h1234;
    init5 = 1'b1;
    @(negedge CLK);
    init5 = 1'b0;
    repeat (10) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_bcd5", {12'd0, bcd5}, 32'd0);
    chk("arst_flags5", {28'd0, neg5, ovf5, busy5, done5}, 32'd0);
    chk("arst_bcd3", {20'd0, bcd3}, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    conv(16'd100, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge CLK);
    chk("q5_drained", q5.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Parametrised sequential binary-to-BCD converter (shift-and-add-3), the next generation of the calculator's Binario-BCD block. Datapath and control FSM are integrated, and width and digit count are generic. It adds a signed (two's complement) mode, an overflow flag for undersized digit counts, a BUSY output and a one-cycle DONE pulse that re-arms for back-to-back conversions. It sits between the calculator ALU result and the 7-segment display driver.

## Interface
- WIDTH, 16, binary operand width in bits (min 4)
- DIGITS, 5, number of BCD output digits (min 1); 5 covers unsigned 16-bit
- CLK  in  1  single clock, all state updates on rising edge
- RST  in  1  reset, asynchronous, active-high
- INIT  in  1  start request, sampled only in S_IDLE
- SGN_MODE  in  1  1 = BIN is two's complement, 0 = unsigned; sampled with BIN
- BIN  in  WIDTH  operand, sampled on the accepting edge only
- BCD  out  4*DIGITS  result, digit 0 (units) in [3:0], registered
- NEG  out  1  result sign, 1 only for a negative signed operand
- OVF  out  1  1 = value does not fit in DIGITS digits
- BUSY  out  1  high whenever state is not S_IDLE
- DONE  out  1  one-cycle pulse, results valid

## Operation
- States: S_IDLE, S_ADJ, S_SHIFT, S_FIN.
- S_IDLE with INIT=1 (accepting edge):
  - Load magnitude into shift register MAG: BIN, or −BIN modulo 2^WIDTH when SGN_MODE=1 and BIN[WIDTH-1]=1. −2^(WIDTH-1) yields unsigned 2^(WIDTH-1).
  - Latch sign, clear working BCD register and sticky overflow.
  - Set counter CNT=WIDTH and go to S_ADJ.
- S_ADJ: add 3 to every working digit ≥5, then go to S_SHIFT.
- S_SHIFT:
  - Shift {workBCD, MAG} left by one.
  - OR the bit leaving workBCD[4*DIGITS-1] into the sticky overflow.
  - Decrement CNT. Go to S_FIN if CNT becomes 0, else to S_ADJ.
- S_FIN:
  - BCD, NEG and OVF were loaded from the working registers on the edge entering S_FIN.
  - DONE=1. Return to S_IDLE next edge.
- BCD, NEG and OVF hold their values until the next entry to S_FIN.
- When OVF=1, BCD equals magnitude mod 10^DIGITS.
- NEG=0 for zero and for every unsigned-mode result.
- INIT in S_ADJ, S_SHIFT or S_FIN is ignored, not queued. BIN and SGN_MODE changes after the accepting edge have no effect.
- Reset (any time, including mid-conversion) immediately forces:
  - state to S_IDLE;
  - BCD, NEG, OVF, DONE and BUSY to 0;
  - all working registers to 0.

## Timing
- Accepting edge = edge 0. ADJ/SHIFT pairs occupy edges 1..2*WIDTH, and S_FIN is entered at edge 2*WIDTH.
- DONE is high for exactly one cycle, between edges 2*WIDTH and 2*WIDTH+1. Latency is 2*WIDTH cycles (32 at default).
- BUSY rises after edge 0 and falls after edge 2*WIDTH+1.
- INIT held high gives one conversion every 2*WIDTH+2 cycles (34 at default).
- Outputs are registered with no combinational path from inputs. CNT width is $clog2(WIDTH+1).

## Structure
- Shared package bbcd_pkg holds:
  - the state enum (S_IDLE, S_ADJ, S_SHIFT, S_FIN);
  - the function bbcd_min_digits(width), returning the digit count that guarantees OVF=0, for bench and instantiation checks.
- Sub-module bcd_digit_adj: purely combinational 4-bit "add 3 if ≥5", instantiated DIGITS times by generate.
- The FSM and datapath stay in one module.

## Test plan
- Default params, SGN_MODE=0, BIN=0xFFFF -> BCD=0x65535, NEG=0, OVF=0, DONE high only in cycle 32 after the accepting edge.
- SGN_MODE=1:
  - BIN=0x8000 -> BCD=0x32768, NEG=1.
  - BIN=0xFFFF -> BCD=0x00001, NEG=1.
  - BIN=0x0000 -> BCD=0, NEG=0.
- DIGITS=3, SGN_MODE=0:
  - BIN=1234 -> BCD=0x234, OVF=1.
  - Following conversion with BIN=999 -> BCD=0x999, OVF=0 (sticky cleared).
- INIT pulsed again and BIN changed while BUSY -> first result unaffected, no extra DONE.
- INIT held high with BIN=42 -> DONE pulses every 34 cycles, BCD=0x00042 each time.
- RST asserted during S_SHIFT -> all outputs 0 and BUSY=0 asynchronously. After release, INIT with BIN=100 -> BCD=0x00100 after 32 cycles.
